// File: rtl/pc_return_stack_if.sv
// Decoder-to-sequencer bundle: operation strobes in, program address and stack status out.
interface pc_return_stack_if #(
    parameter int unsigned ADDR_W = 10,
    parameter int unsigned DEPTH  = 5
);
    localparam int unsigned DEP_W = $clog2(DEPTH + 1);

    logic              inc;
    logic              jmp;
    logic              call;
    logic              ret;
    logic              tgt_full;
    logic [ADDR_W-1:0] tgt;
    logic              flag_clr;
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] tos;
    logic [DEP_W-1:0]  depth;
    logic              full;
    logic              empty;
    logic              ovf;
    logic              unf;

    modport master (
        output inc, jmp, call, ret, tgt_full, tgt, flag_clr,
        input  pc, tos, depth, full, empty, ovf, unf
    );

    modport slave (
        input  inc, jmp, call, ret, tgt_full, tgt, flag_clr,
        output pc, tos, depth, full, empty, ovf, unf
    );
endinterface

// File: rtl/pc_return_stack.sv
// Program-counter sequencer with a shift-register return-address stack,
// valid-depth tracking and sticky overflow/underflow flags.
module pc_return_stack #(
    parameter int unsigned           ADDR_W    = 10,
    parameter int unsigned           PL_W      = 6,
    parameter int unsigned           PL_MODE   = 0,
    parameter int unsigned           DEPTH     = 5,
    parameter logic [ADDR_W-PL_W-1:0] CALL_PAGE = '1,
    parameter int unsigned           OVF_MODE  = 0
) (
    input logic                clk,
    input logic                rst_n,
    pc_return_stack_if.slave   bus
);
    localparam int unsigned DEP_W = $clog2(DEPTH + 1);
    localparam int unsigned PG_W  = ADDR_W - PL_W;

    logic [ADDR_W-1:0]             pc_q, pc_d;
    logic [DEPTH-1:0][ADDR_W-1:0]  stack_q, stack_d;
    logic [DEP_W-1:0]              depth_q, depth_d;
    logic                          ovf_q, ovf_d;
    logic                          unf_q, unf_d;
    logic                          full_w;
    logic                          empty_w;
    logic [ADDR_W-1:0]             seq_pc;

    // Sequential successor: only the in-page field advances, the page never carries.
    function automatic logic [ADDR_W-1:0] seq_next(input logic [ADDR_W-1:0] a);
        logic [PL_W-1:0] pl;
        pl = a[PL_W-1:0];
        if (PL_MODE == 0) begin
            pl = {~(pl[0] ^ pl[1]), pl[PL_W-1:1]};
        end else begin
            pl = pl + PL_W'(1);
        end
        return {a[ADDR_W-1:PL_W], pl};
    endfunction

    assign seq_pc  = seq_next(pc_q);
    assign full_w  = (depth_q == DEP_W'(DEPTH));
    assign empty_w = (depth_q == '0);

    always_comb begin
        pc_d    = pc_q;
        stack_d = stack_q;
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;

        // Clear first so a same-cycle set below wins.
        if (bus.flag_clr) begin
            ovf_d = 1'b0;
            unf_d = 1'b0;
        end

        if (bus.ret) begin
            pc_d = stack_q[0];
            for (int unsigned i = 0; i + 1 < DEPTH; i++) begin
                stack_d[i] = stack_q[i+1];
            end
            if (empty_w) begin
                unf_d = 1'b1;
            end else begin
                depth_d = depth_q - DEP_W'(1);
            end
        end else if (bus.call) begin
            pc_d = bus.tgt_full ? bus.tgt : {CALL_PAGE, bus.tgt[PL_W-1:0]};
            if (full_w) begin
                ovf_d = 1'b1;
            end
            if (!(full_w && OVF_MODE == 1)) begin
                for (int unsigned i = DEPTH - 1; i > 0; i--) begin
                    stack_d[i] = stack_q[i-1];
                end
                stack_d[0] = seq_pc;
                if (!full_w) begin
                    depth_d = depth_q + DEP_W'(1);
                end
            end
        end else if (bus.jmp) begin
            pc_d = bus.tgt_full ? bus.tgt : {pc_q[ADDR_W-1:PL_W], bus.tgt[PL_W-1:0]};
        end else if (bus.inc) begin
            pc_d = seq_pc;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= '0;
            stack_q <= '0;
            depth_q <= '0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            stack_q <= stack_d;
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign bus.pc    = pc_q;
    assign bus.tos   = stack_q[0];
    assign bus.depth = depth_q;
    assign bus.full  = full_w;
    assign bus.empty = empty_w;
    assign bus.ovf   = ovf_q;
    assign bus.unf   = unf_q;

    // Page field must be non-empty for the {page, low} concatenations.
    if (PG_W == 0) begin : g_bad_width
        $error("ADDR_W must exceed PL_W");
    end
endmodule

// File: tb/tb_pc_return_stack.sv
// Directed bench for pc_return_stack: one instance per overflow mode, driven in lockstep.
module tb_pc_return_stack;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       inc, jmp, call, ret, tgt_full, flag_clr;
    logic [9:0] tgt;
    int         passed = 0;
    int         total  = 0;
    logic [9:0] exp0 [5];
    logic [9:0] exp1 [5];

    always #5 clk = ~clk;

    pc_return_stack_if #(.ADDR_W(10), .DEPTH(5)) bus0 ();
    pc_return_stack_if #(.ADDR_W(10), .DEPTH(5)) bus1 ();

    assign bus0.inc = inc;  assign bus0.jmp = jmp;  assign bus0.call = call;
    assign bus0.ret = ret;  assign bus0.tgt_full = tgt_full;
    assign bus0.tgt = tgt;  assign bus0.flag_clr = flag_clr;
    assign bus1.inc = inc;  assign bus1.jmp = jmp;  assign bus1.call = call;
    assign bus1.ret = ret;  assign bus1.tgt_full = tgt_full;
    assign bus1.tgt = tgt;  assign bus1.flag_clr = flag_clr;

    pc_return_stack #(.OVF_MODE(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));
    pc_return_stack #(.OVF_MODE(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic op(input logic i_inc, input logic i_jmp, input logic i_call,
                      input logic i_ret, input logic i_full, input logic i_clr,
                      input logic [9:0] t);
        @(negedge clk);
        inc = i_inc; jmp = i_jmp; call = i_call; ret = i_ret;
        tgt_full = i_full; flag_clr = i_clr; tgt = t;
        @(posedge clk);
        #1;
        inc = 1'b0; jmp = 1'b0; call = 1'b0; ret = 1'b0;
        tgt_full = 1'b0; flag_clr = 1'b0; tgt = '0;
    endtask

    task automatic do_inc();                 op(1, 0, 0, 0, 0, 0, '0); endtask
    task automatic do_ret();                 op(0, 0, 0, 1, 0, 0, '0); endtask
    task automatic do_call(input logic [9:0] t); op(0, 0, 1, 0, 0, 0, t); endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        inc = 1'b0; jmp = 1'b0; call = 1'b0; ret = 1'b0;
        tgt_full = 1'b0; flag_clr = 1'b0; tgt = '0;
        exp0 = '{10'h3C2, 10'h3E2, 10'h3E1, 10'h3C1, 10'h3C0};
        exp1 = '{10'h3E2, 10'h3E1, 10'h3C1, 10'h3C0, 10'h020};
        #12;
        rst_n = 1'b1;

        // Reset state
        chk("rst_pc",    32'(bus0.pc), 32'h0);
        chk("rst_tos",   32'(bus0.tos), 32'h0);
        chk("rst_depth", 32'(bus0.depth), 32'h0);
        chk("rst_empty", 32'(bus0.empty), 32'h1);
        chk("rst_full",  32'(bus0.full), 32'h0);
        chk("rst_ovf",   32'(bus0.ovf), 32'h0);
        chk("rst_unf",   32'(bus0.unf), 32'h0);

        // LFSR sequence and full period
        do_inc(); chk("inc1", 32'(bus0.pc), 32'h020);
        do_inc(); chk("inc2", 32'(bus0.pc), 32'h030);
        do_inc(); chk("inc3", 32'(bus0.pc), 32'h038);
        for (int k = 0; k < 60; k++) begin
            do_inc();
            chk("lfsr_no_3f", 32'(bus0.pc[5:0] == 6'h3F), 32'h0);
        end
        chk("lfsr_period", 32'(bus0.pc), 32'h000);

        // Short call then return
        do_call(10'h015);
        chk("call_pc",    32'(bus0.pc), 32'h3D5);
        chk("call_tos",   32'(bus0.tos), 32'h020);
        chk("call_depth", 32'(bus0.depth), 32'h1);
        do_ret();
        chk("ret_pc",    32'(bus0.pc), 32'h020);
        chk("ret_depth", 32'(bus0.depth), 32'h0);
        chk("ret_empty", 32'(bus0.empty), 32'h1);
        chk("ret_ovf",   32'(bus0.ovf), 32'h0);
        chk("ret_unf",   32'(bus0.unf), 32'h0);

        // Overflow / underflow in both modes
        pulse_reset();
        for (int k = 1; k <= 6; k++) begin
            do_call(10'(k));
            chk("ovf_depth0", 32'(bus0.depth), 32'((k > 5) ? 5 : k));
            chk("ovf_depth1", 32'(bus1.depth), 32'((k > 5) ? 5 : k));
            if (k == 5) chk("full_at5", 32'(bus0.full), 32'h1);
        end
        chk("ovf_pc",    32'(bus0.pc), 32'h3C6);
        chk("ovf_flag0", 32'(bus0.ovf), 32'h1);
        chk("ovf_flag1", 32'(bus1.ovf), 32'h1);
        chk("ovf_tos0",  32'(bus0.tos), 32'h3C2);
        chk("ovf_tos1",  32'(bus1.tos), 32'h3E2);
        for (int k = 0; k < 5; k++) begin
            do_ret();
            chk("lifo_pc0", 32'(bus0.pc), 32'(exp0[k]));
            chk("lifo_pc1", 32'(bus1.pc), 32'(exp1[k]));
            chk("lifo_depth", 32'(bus0.depth), 32'(4 - k));
        end
        chk("unf_pre", 32'(bus0.unf), 32'h0);
        do_ret();
        chk("unf_pc0",    32'(bus0.pc), 32'h3C0);
        chk("unf_pc1",    32'(bus1.pc), 32'h020);
        chk("unf_flag0",  32'(bus0.unf), 32'h1);
        chk("unf_flag1",  32'(bus1.unf), 32'h1);
        chk("unf_depth",  32'(bus0.depth), 32'h0);

        // Strobe priority and jumps
        pulse_reset();
        do_call(10'h001);
        do_call(10'h002);
        chk("prio_pre_depth", 32'(bus0.depth), 32'h2);
        chk("prio_pre_tos",   32'(bus0.tos), 32'h3C0);
        op(1, 0, 1, 1, 0, 0, 10'h011);
        chk("prio_ret_pc",    32'(bus0.pc), 32'h3C0);
        chk("prio_ret_depth", 32'(bus0.depth), 32'h1);
        op(1, 1, 0, 0, 1, 0, 10'h2AB);
        chk("jmp_long", 32'(bus0.pc), 32'h2AB);
        op(0, 1, 0, 0, 0, 0, 10'h005);
        chk("jmp_short", 32'(bus0.pc), 32'h285);

        // Set beats clear
        pulse_reset();
        for (int k = 0; k < 5; k++) do_call(10'h010);
        op(0, 0, 1, 0, 0, 1, 10'h010);
        chk("clr_vs_set0", 32'(bus0.ovf), 32'h1);
        chk("clr_vs_set1", 32'(bus1.ovf), 32'h1);
        op(0, 0, 0, 0, 0, 1, '0);
        chk("clr_alone", 32'(bus0.ovf), 32'h0);

        // Async reset mid-operation
        pulse_reset();
        do_ret();
        chk("pre_unf", 32'(bus0.unf), 32'h1);
        for (int k = 0; k < 3; k++) do_call(10'h015);
        chk("pre_pc",    32'(bus0.pc), 32'h3D5);
        chk("pre_depth", 32'(bus0.depth), 32'h3);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_pc",    32'(bus0.pc), 32'h0);
        chk("arst_depth", 32'(bus0.depth), 32'h0);
        chk("arst_tos",   32'(bus0.tos), 32'h0);
        chk("arst_ovf",   32'(bus0.ovf), 32'h0);
        chk("arst_unf",   32'(bus0.unf), 32'h0);
        chk("arst_empty", 32'(bus0.empty), 32'h1);
        #1;
        rst_n = 1'b1;
        do_inc();
        chk("arst_inc", 32'(bus0.pc), 32'h020);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/pc_return_stack.md
# pc_return_stack

Parametrised program-counter sequencer with an integrated return-address stack. It is the successor to the fixed 10-bit PC / five-level shift-register stack used in our 4-bit controller cores. It adds configurable address width, stack depth, low-field count mode and call page, plus a valid-depth counter and sticky overflow/underflow flags. It sits between the instruction decoder, which issues strobes, and the program ROM address bus.

## Interface
- ADDR_W, 10: total PC width. The page field is the upper ADDR_W-PL_W bits.
- PL_W, 6: width of the low (in-page) field. Must be at least 2.
- PL_MODE, 0: low-field count mode. 0 = XNOR LFSR, 1 = binary +1 wrapping within the page.
- DEPTH, 5: number of stack entries. Must be at least 1.
- CALL_PAGE, all ones: page loaded on a short call.
- OVF_MODE, 0: behaviour on push when full. 0 = discard the oldest entry. 1 = refuse the push.

- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- inc  in  1  advance PC to its sequential successor
- jmp  in  1  jump to target
- call  in  1  push return address, then jump
- ret  in  1  pop top of stack into PC
- tgt_full  in  1  1 = load the page from tgt as well (long form); 0 = short form
- tgt  in  ADDR_W  jump/call target
- flag_clr  in  1  clear ovf and unf
- pc  out  ADDR_W  current program address
- tos  out  ADDR_W  stack entry 0 (top)
- depth  out  clog2(DEPTH+1)  number of valid entries
- full  out  1  depth == DEPTH
- empty  out  1  depth == 0
- ovf  out  1  sticky: push attempted while full
- unf  out  1  sticky: pop attempted while empty

## Operation
- Only one operation executes per clock. Priority is ret > call > jmp > inc. Lower-priority strobes asserted in the same cycle are ignored. With no strobe, all state holds.
- Sequential successor next(pc): the page field is unchanged.
  - PL_MODE 0: low field shifts right, and the new MSB = XNOR(PL[0], PL[1]). All-ones is a lockup state. It is reachable only by a jump load and is held there.
  - PL_MODE 1: low field = (PL+1) mod 2^PL_W. There is no carry into the page.
- inc: pc <= next(pc).
- jmp, short form: pc <= {page, tgt[PL_W-1:0]}, keeping the current page. Long form: pc <= tgt.
- call:
  - The return address is next(pc).
  - Push shifts entries down (entry i to i+1) and writes the return address to entry 0.
  - PC target: short form gives pc <= {CALL_PAGE, tgt[PL_W-1:0]}; long form gives pc <= tgt.
- ret: pc <= entry 0. Entries shift up (i+1 to i). Entry DEPTH-1 keeps its value, so the bottom entry is duplicated.
- Stack is full (depth == DEPTH) when call executes:
  - ovf is set.
  - OVF_MODE 0: push proceeds, entry DEPTH-1 is lost, depth stays at DEPTH.
  - OVF_MODE 1: push is suppressed and the stack is unchanged.
  - The PC jump happens in both modes.
- Stack is empty (depth == 0) when ret executes:
  - unf is set and depth stays 0.
  - The stale entry 0 is still loaded into pc, and the shift still occurs.
- Otherwise, depth increments on call and decrements on ret.
- Flags: set has priority over flag_clr in the same cycle.

## Timing
- All state (pc, stack, depth, ovf, unf) is registered on the rising edge of clk.
- Every operation has one-cycle latency: the strobe is sampled at edge N and its results are visible after edge N.
- tos, full and empty are combinational from registers. They have no input-to-output combinational paths.
- Reset (rst_n low) takes effect immediately, independent of clk, including mid-operation:
  - pc = 0
  - all stack entries = 0
  - depth = 0
  - ovf = unf = 0
  - Hence tos = 0, empty = 1, full = 0.
- Strobes sampled at the first edge after rst_n rises are executed normally.
- The block has no handshake. The decoder guarantees strobes are single-cycle pulses; held strobes repeat the operation every cycle.

## Test plan
All scenarios use the default parameters.
- Reset, then inc ×3: pc = 0x020, 0x030, 0x038. Then inc ×60 more: pc = 0x000. Over the full 63-step period, low field 0x3F is never visited.
- From pc=0x000, call with tgt_full=0 and tgt=0x015: pc=0x3D5, tos=0x020, depth=1. Then ret: pc=0x020, depth=0, empty=1, ovf=unf=0.
- Six short calls to tgt values 1..6, starting at pc=0x000: the sixth sets ovf=1 and depth stays 5. Five rets return the five newest return addresses in LIFO order. A sixth ret sets unf=1 and reloads the duplicated bottom entry. Repeat with OVF_MODE=1: the sixth push is refused and the first pushed address is retained.
- call, ret and inc asserted together with depth=2: only ret executes, so pc = old tos and depth=1. jmp+inc together: only jmp executes. Long jmp with tgt=0x2AB gives pc=0x2AB. A following short jmp with tgt=0x005 gives pc=0x285.
- flag_clr asserted in the same cycle as an overflowing call: ovf=1. flag_clr alone on the next cycle: ovf=0.
- rst_n pulsed low between clock edges while depth=3 and pc=0x3D5: pc, depth, tos, ovf and unf read 0 before the next edge. The first inc after release gives pc=0x020.
